// File: rtl/renkon_ctrl_wb_if.sv
// rtl/renkon_ctrl_wb_if.sv - control stream bus between the last pipeline stage and the write-back sink
//
// Purpose: carries the start/valid/stop beat stream downstream and ready upstream.
// Signals:
//   start  frame start marker (master -> slave)
//   valid  data beat marker (master -> slave)
//   stop   frame end marker (master -> slave)
//   delay  per-frame delay word, meaningful with start (master -> slave)
//   ready  sink is accepting the stream (slave -> master)
interface renkon_ctrl_wb_if #(
    parameter int LWIDTH = 16
);
    logic              start;
    logic              valid;
    logic              stop;
    logic [LWIDTH-1:0] delay;
    logic              ready;

    modport master (
        output start,
        output valid,
        output stop,
        output delay,
        input  ready
    );

    modport slave (
        input  start,
        input  valid,
        input  stop,
        input  delay,
        output ready
    );
endinterface

// File: rtl/renkon_ctrl_wb.sv
// rtl/renkon_ctrl_wb.sv - write-back control sink turning the control stream into output-buffer writes
//
// Purpose: armed by req, accepts one frame of start/valid/stop beats, issues one
// registered write per valid beat at base+count, flags overrun/underrun against
// the configured size and pulses ack when the frame is done.
// Ports:
//   clk, xrst              clock, asynchronous active-low reset
//   req                    arm pulse, honoured only when idle
//   _out_base, _out_size   first write address / expected beat count, latched on req
//   in_ctrl                control stream (slave side), drives ready
//   mem_we, mem_addr       registered output-buffer write strobe and address
//   ack                    one-cycle frame-done pulse
//   busy                   not idle
//   overrun, underrun      sticky frame error flags, cleared on the next req
//   frame_delay            delay word captured with start
module renkon_ctrl_wb #(
    parameter int MEMADDR = 12,
    parameter int LWIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  xrst,
    input  logic                  req,
    input  logic [MEMADDR-1:0]    _out_base,
    input  logic [MEMADDR-1:0]    _out_size,
    renkon_ctrl_wb_if.slave       in_ctrl,
    output logic                  mem_we,
    output logic [MEMADDR-1:0]    mem_addr,
    output logic                  ack,
    output logic                  busy,
    output logic                  overrun,
    output logic                  underrun,
    output logic [LWIDTH-1:0]     frame_delay
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RECV  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [MEMADDR-1:0] r_base;
    logic [MEMADDR-1:0] r_size;
    // One bit wider than the size so a full-size frame never wraps back to 0.
    logic [MEMADDR:0]   r_count;
    logic               r_ready;
    logic               r_busy;
    logic               r_ack;
    logic               r_mem_we;
    logic [MEMADDR-1:0] r_mem_addr;
    logic               r_overrun;
    logic               r_underrun;
    logic [LWIDTH-1:0]  r_frame_delay;

    logic               w_room;
    logic               w_accept;
    logic [MEMADDR:0]   w_next_count;
    logic [MEMADDR-1:0] w_wr_addr;

    assign w_room       = (r_count < {1'b0, r_size});
    assign w_accept     = in_ctrl.valid && w_room;
    assign w_next_count = r_count + {{MEMADDR{1'b0}}, w_accept};
    assign w_wr_addr    = r_base + r_count[MEMADDR-1:0];

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_size        <= '0;
            r_count       <= '0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_ack         <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_overrun     <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_delay <= '0;
        end else begin
            r_mem_we <= 1'b0;
            r_ack    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_base     <= _out_base;
                        r_size     <= _out_size;
                        r_count    <= '0;
                        r_overrun  <= 1'b0;
                        r_underrun <= 1'b0;
                        r_busy     <= 1'b1;
                        if (_out_size != '0) begin
                            r_state <= S_ARMED;
                            r_ready <= 1'b1;
                        end else begin
                            // Empty frame: complete immediately without opening the stream.
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
                        end
                    end
                end
                S_ARMED, S_RECV: begin
                    // In S_ARMED nothing happens until start; start's own cycle
                    // is then handled exactly like a receive cycle.
                    if (r_state == S_RECV || in_ctrl.start) begin
                        if (r_state == S_ARMED) begin
                            r_frame_delay <= in_ctrl.delay;
                            r_state       <= S_RECV;
                        end
                        if (w_accept) begin
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= w_wr_addr;
                            r_count    <= w_next_count;
                        end else if (in_ctrl.valid) begin
                            r_overrun <= 1'b1;
                        end
                        if (in_ctrl.stop) begin
                            // Judge underrun on the count including this cycle's beat.
                            if (w_next_count < {1'b0, r_size})
                                r_underrun <= 1'b1;
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_ack   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ctrl.ready = r_ready;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign ack           = r_ack;
    assign busy          = r_busy;
    assign overrun       = r_overrun;
    assign underrun      = r_underrun;
    assign frame_delay   = r_frame_delay;

endmodule

// File: tb/tb_renkon_ctrl_wb.sv
// tb/tb_renkon_ctrl_wb.sv - self-checking bench for renkon_ctrl_wb
module tb_renkon_ctrl_wb;

    localparam int MEMADDR = 12;
    localparam int LWIDTH  = 16;

    logic               clk;
    logic               xrst;
    logic               req;
    logic [MEMADDR-1:0] out_base;
    logic [MEMADDR-1:0] out_size;
    logic               mem_we;
    logic [MEMADDR-1:0] mem_addr;
    logic               ack;
    logic               busy;
    logic               overrun;
    logic               underrun;
    logic [LWIDTH-1:0]  frame_delay;

    renkon_ctrl_wb_if #(.LWIDTH(LWIDTH)) bus ();

    renkon_ctrl_wb #(.MEMADDR(MEMADDR), .LWIDTH(LWIDTH)) dut (
        .clk         (clk),
        .xrst        (xrst),
        .req         (req),
        ._out_base   (out_base),
        ._out_size   (out_size),
        .in_ctrl     (bus),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .ack         (ack),
        .busy        (busy),
        .overrun     (overrun),
        .underrun    (underrun),
        .frame_delay (frame_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [MEMADDR-1:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every write strobe must match the oldest expected address.
    always @(negedge clk) begin
        if (xrst && mem_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h expected no write at %0t", mem_addr, $time);
            end else begin
                chk("write_addr", 32'(mem_addr), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [MEMADDR-1:0] base;
        logic [MEMADDR-1:0] size;
        int                 nbeats;
        int                 gap;
        bit                 stop_sep;
        logic [LWIDTH-1:0]  delay;
        bit                 exp_ov;
        bit                 exp_un;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int cnt;
        logic [MEMADDR-1:0] a;
        cnt = 0;
        req = 1'b1; out_base = v.base; out_size = v.size;
        tick();
        req = 1'b0; out_base = '0; out_size = '0;
        chk("armed_ready", 32'(bus.ready), 32'd1);
        chk("armed_busy", 32'(busy), 32'd1);
        bus.delay = v.delay;
        for (int i = 0; i < v.nbeats; i++) begin
            bus.start = (i == 0);
            bus.valid = 1'b1;
            bus.stop  = (!v.stop_sep && i == v.nbeats - 1);
            if (cnt < int'(v.size)) begin
                a = v.base + cnt[MEMADDR-1:0];
                sb.push_back(a);
                cnt++;
            end
            tick();
            bus.start = 1'b0; bus.valid = 1'b0; bus.stop = 1'b0;
            bus.delay = 16'hdead;
            chk("overrun_timing", 32'(overrun), 32'(i + 1 > int'(v.size)));
            if (i != v.nbeats - 1 || v.stop_sep) begin
                for (int g = 0; g < v.gap; g++) begin
                    chk("recv_ready", 32'(bus.ready), 32'd1);
                    tick();
                end
                chk("recv_ready", 32'(bus.ready), 32'd1);
            end
        end
        if (v.stop_sep) begin
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
        end
        chk("done_ack", 32'(ack), 32'd1);
        chk("done_ready", 32'(bus.ready), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("overrun", 32'(overrun), 32'(v.exp_ov));
        chk("underrun", 32'(underrun), 32'(v.exp_un));
        chk("frame_delay", 32'(frame_delay), 32'(v.delay));
        tick();
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(bus.ready), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("flags_held", 32'({overrun, underrun}), 32'({v.exp_ov, v.exp_un}));
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{base: 12'h100, size: 12'd4, nbeats: 4, gap: 0, stop_sep: 1'b0, delay: 16'h1234, exp_ov: 1'b0, exp_un: 1'b0};
        vecs[1] = '{base: 12'h230, size: 12'd3, nbeats: 3, gap: 2, stop_sep: 1'b0, delay: 16'h0042, exp_ov: 1'b0, exp_un: 1'b0};
        vecs[2] = '{base: 12'h040, size: 12'd2, nbeats: 4, gap: 0, stop_sep: 1'b1, delay: 16'h0777, exp_ov: 1'b1, exp_un: 1'b0};
        vecs[3] = '{base: 12'hFFE, size: 12'd4, nbeats: 3, gap: 0, stop_sep: 1'b1, delay: 16'hBEEF, exp_ov: 1'b0, exp_un: 1'b1};
        vecs[4] = '{base: 12'h555, size: 12'd1, nbeats: 1, gap: 0, stop_sep: 1'b0, delay: 16'h0001, exp_ov: 1'b0, exp_un: 1'b0};

        xrst = 1'b0; req = 1'b0; out_base = '0; out_size = '0;
        bus.start = 1'b0; bus.valid = 1'b0; bus.stop = 1'b0; bus.delay = '0;
        repeat (2) tick();
        chk("rst_outputs", 32'({bus.ready, mem_we, ack, busy, overrun, underrun}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_delay", 32'(frame_delay), 32'd0);
        xrst = 1'b1;
        tick();

        // Stream without a req must be ignored.
        bus.start = 1'b1; bus.valid = 1'b1;
        tick();
        bus.start = 1'b0; bus.valid = 1'b0;
        chk("noreq_busy", 32'(busy), 32'd0);

        foreach (vecs[k]) begin
            run_frame(vecs[k]);
            tick();
        end

        // Zero-size frame completes at once without opening the stream.
        req = 1'b1; out_base = 12'h321; out_size = 12'd0;
        tick();
        req = 1'b0;
        chk("zero_ack", 32'(ack), 32'd1);
        chk("zero_ready", 32'(bus.ready), 32'd0);
        chk("zero_busy", 32'(busy), 32'd1);
        bus.start = 1'b1; bus.valid = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.valid = 1'b0; bus.stop = 1'b0;
        chk("zero_idle_ack", 32'(ack), 32'd0);
        chk("zero_idle_busy", 32'(busy), 32'd0);
        tick();

        // Reset in the middle of a frame after two beats.
        req = 1'b1; out_base = 12'h300; out_size = 12'd8;
        tick();
        req = 1'b0;
        bus.start = 1'b1; bus.valid = 1'b1; bus.delay = 16'h5A5A;
        sb.push_back(12'h300);
        tick();
        bus.start = 1'b0;
        sb.push_back(12'h301);
        tick();
        bus.valid = 1'b0;
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        #1;
        bus.valid = 1'b1;
        xrst = 1'b0;
        #1;
        chk("midrst_outputs", 32'({bus.ready, mem_we, ack, busy, overrun, underrun}), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_delay", 32'(frame_delay), 32'd0);
        tick();
        xrst = 1'b1;
        bus.start = 1'b1; bus.valid = 1'b1; bus.stop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.start = (c == 2);
            chk("post_rst_ready", 32'(bus.ready), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_we", 32'(mem_we), 32'd0);
        end
        bus.start = 1'b0; bus.valid = 1'b0;
        tick();
        tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
